// File: rtl/valve_driver.sv
// valve_driver: turns level commands for four latching solenoid valves into
// timed open/close drive pulses on a single shared H-bridge.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   R1[1:0]      zone-1 command: R1[1] = valve0, R1[0] = valve1
//   R2[1:0]      zone-2 command: R2[1] = valve2, R2[0] = valve3
//   E[1:0]       controller status: 2'b01 normal, anything else is a fault
//   open_pulse   per-valve open drive pulse
//   close_pulse  per-valve close drive pulse
//   valve_on     valve is in OPEN
//   timeout      sticky per-valve watchdog flag
//   fault_active registered fault indication
//   busy         a pulse is running or some valve has a pending request
module valve_driver #(
  parameter int unsigned PULSE_CYC  = 4,
  parameter int unsigned MIN_ON_CYC = 8,
  parameter int unsigned MAX_ON_CYC = 1000,
  parameter int unsigned CW         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] R1,
  input  logic [1:0] R2,
  input  logic [1:0] E,
  output logic [3:0] open_pulse,
  output logic [3:0] close_pulse,
  output logic [3:0] valve_on,
  output logic [3:0] timeout,
  output logic       fault_active,
  output logic       busy
);

  localparam int unsigned NV = 4;
  localparam int unsigned PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] MIN_ON     = CW'(MIN_ON_CYC);
  localparam logic [CW-1:0] MAX_ON     = CW'(MAX_ON_CYC);

  typedef enum logic [2:0] {
    HOME    = 3'd0,
    CLOSED  = 3'd1,
    OPENING = 3'd2,
    OPEN    = 3'd3,
    CLOSING = 3'd4
  } vstate_t;

  vstate_t       state_q  [NV];
  vstate_t       state_d  [NV];
  logic [CW-1:0] on_cnt_q [NV];
  logic [CW-1:0] on_cnt_d [NV];
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [NV-1:0] cmd_q, cmd_d;
  logic          fault_q, fault_d;
  logic [NV-1:0] timeout_d;
  logic [NV-1:0] open_req_c, close_req_c, grant_c;
  logic          pulse_active_c;
  logic [NV-1:0] open_pulse_d, close_pulse_d, valve_on_d;
  logic          busy_d;

  // Request decode for one valve: returns {close_req, open_req}.
  function automatic logic [1:0] req_of(vstate_t st, logic cmd, logic flt,
                                        logic to, logic [CW-1:0] cnt);
    logic want;
    logic opn;
    logic cls;
    want = cmd & ~flt & ~to;
    opn  = (st == CLOSED) & want;
    cls  = (st == HOME) |
           ((st == OPEN) & (flt | (cnt >= MAX_ON) | (~want & (cnt >= MIN_ON))));
    return {cls, opn};
  endfunction

  assign fault_active = fault_q;

  // Next-state, arbitration and next-output logic.
  always_comb begin
    logic [1:0] nreq;
    nreq           = '0;
    cmd_d          = {R2[0], R2[1], R1[0], R1[1]};
    fault_d        = (E != 2'b01);
    pcnt_d         = pcnt_q;
    timeout_d      = timeout;
    grant_c        = '0;
    open_req_c     = '0;
    close_req_c    = '0;
    pulse_active_c = 1'b0;
    open_pulse_d   = '0;
    close_pulse_d  = '0;
    valve_on_d     = '0;
    busy_d         = 1'b0;

    for (int i = 0; i < NV; i++) begin
      state_d[i]  = state_q[i];
      on_cnt_d[i] = '0;
      {close_req_c[i], open_req_c[i]} =
        req_of(state_q[i], cmd_q[i], fault_q, timeout[i], on_cnt_q[i]);
      if (state_q[i] == OPENING || state_q[i] == CLOSING) pulse_active_c = 1'b1;
    end

    // Single grant while the bridge is idle: closes first, lowest index first.
    if (!pulse_active_c) begin
      if (|close_req_c) grant_c = close_req_c & (~close_req_c + NV'(1));
      else              grant_c = open_req_c & (~open_req_c + NV'(1));
    end

    if (pulse_active_c && (pcnt_q != '0)) pcnt_d = pcnt_q - PW'(1);

    for (int i = 0; i < NV; i++) begin
      // Close requests exist only in HOME/OPEN, open requests only in CLOSED.
      case (state_q[i])
        HOME, OPEN: begin
          if (grant_c[i]) begin
            state_d[i] = CLOSING;
            pcnt_d     = PULSE_LOAD;
          end
        end
        CLOSED: begin
          if (grant_c[i]) begin
            state_d[i] = OPENING;
            pcnt_d     = PULSE_LOAD;
          end
        end
        OPENING: if (pcnt_q == '0) state_d[i] = OPEN;
        CLOSING: if (pcnt_q == '0) state_d[i] = CLOSED;
        default: state_d[i] = HOME;
      endcase

      // On-time counts only while staying in OPEN; entry clears it.
      if (state_q[i] == OPEN && state_d[i] == OPEN) begin
        on_cnt_d[i] = (on_cnt_q[i] >= MAX_ON) ? MAX_ON : on_cnt_q[i] + CW'(1);
        if (on_cnt_d[i] == MAX_ON) timeout_d[i] = 1'b1;
      end
      if (state_q[i] == CLOSED && !cmd_q[i]) timeout_d[i] = 1'b0;

      open_pulse_d[i]  = (state_d[i] == OPENING);
      close_pulse_d[i] = (state_d[i] == CLOSING);
      valve_on_d[i]    = (state_d[i] == OPEN);
      nreq   = req_of(state_d[i], cmd_d[i], fault_d, timeout_d[i], on_cnt_d[i]);
      busy_d = busy_d | (|nreq) | open_pulse_d[i] | close_pulse_d[i];
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NV; i++) begin
        state_q[i]  <= HOME;
        on_cnt_q[i] <= '0;
      end
      pcnt_q      <= '0;
      cmd_q       <= '0;
      fault_q     <= 1'b0;
      timeout     <= '0;
      open_pulse  <= '0;
      close_pulse <= '0;
      valve_on    <= '0;
      busy        <= 1'b0;
    end else begin
      for (int i = 0; i < NV; i++) begin
        state_q[i]  <= state_d[i];
        on_cnt_q[i] <= on_cnt_d[i];
      end
      pcnt_q      <= pcnt_d;
      cmd_q       <= cmd_d;
      fault_q     <= fault_d;
      timeout     <= timeout_d;
      open_pulse  <= open_pulse_d;
      close_pulse <= close_pulse_d;
      valve_on    <= valve_on_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_valve_driver.sv
// Bench for valve_driver: cycle model of valve positions plus a single
// shared-bridge pulse record, compared every cycle, with directed checks.
module tb_valve_driver;

  localparam int unsigned PULSE = 4;
  localparam int unsigned MINC  = 8;
  localparam int unsigned MAXC  = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] R1, R2, E;
  logic [3:0] open_pulse, close_pulse, valve_on, timeout;
  logic       fault_active, busy;

  int n_tests = 0;
  int n_fail  = 0;

  valve_driver #(
    .PULSE_CYC (PULSE),
    .MIN_ON_CYC(MINC),
    .MAX_ON_CYC(MAXC),
    .CW        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .R1          (R1),
    .R2          (R2),
    .E           (E),
    .open_pulse  (open_pulse),
    .close_pulse (close_pulse),
    .valve_on    (valve_on),
    .timeout     (timeout),
    .fault_active(fault_active),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // homed: valve position known (has completed a close); open: valve is open.
  bit m_homed [4];
  bit m_open  [4];
  bit m_to    [4];
  bit m_cmd   [4];
  int m_on    [4];
  bit m_flt        = 1'b0;
  bit m_after_rst  = 1'b0;
  bit m_valid      = 1'b0;
  int pv           = -1;   // valve currently driven by the bridge, -1 if none
  bit p_open       = 1'b0; // that pulse is an open pulse
  int p_left       = 0;

  function automatic bit m_want(int i);
    return m_cmd[i] && !m_flt && !m_to[i];
  endfunction

  function automatic bit m_close_req(int i);
    if (pv == i)      return 1'b0;
    if (!m_homed[i])  return 1'b1;
    if (!m_open[i])   return 1'b0;
    return m_flt || (m_on[i] >= int'(MAXC)) || (!m_want(i) && (m_on[i] >= int'(MINC)));
  endfunction

  function automatic bit m_open_req(int i);
    return (pv != i) && m_homed[i] && !m_open[i] && m_want(i);
  endfunction

  always @(posedge clk) begin : model_step
    bit creq [4];
    bit oreq [4];
    bit tclr [4];
    int g;
    bit gclose;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_homed[i] = 0; m_open[i] = 0; m_to[i] = 0; m_cmd[i] = 0; m_on[i] = 0;
      end
      m_flt = 0; pv = -1; p_left = 0; p_open = 0;
      m_after_rst = 1; m_valid = 1;
    end else begin
      g = -1;
      gclose = 0;
      for (int i = 0; i < 4; i++) begin
        creq[i] = m_close_req(i);
        oreq[i] = m_open_req(i);
        tclr[i] = m_homed[i] && !m_open[i] && (pv != i) && !m_cmd[i];
      end
      if (pv < 0) begin
        for (int i = 3; i >= 0; i--) if (creq[i]) begin g = i; gclose = 1; end
        if (g < 0) for (int i = 3; i >= 0; i--) if (oreq[i]) g = i;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_open[i] && !(gclose && g == i)) begin
          if (m_on[i] < int'(MAXC)) m_on[i]++;
          if (m_on[i] == int'(MAXC)) m_to[i] = 1;
        end
        if (tclr[i]) m_to[i] = 0;
      end
      if (pv >= 0) begin
        p_left--;
        if (p_left == 0) begin
          if (p_open) begin m_open[pv] = 1; m_on[pv] = 0; end
          else        m_homed[pv] = 1;
          pv = -1;
        end
      end else if (g >= 0) begin
        pv = g; p_open = !gclose; p_left = int'(PULSE);
        if (gclose) m_open[g] = 0;
      end
      m_cmd[0] = R1[1]; m_cmd[1] = R1[0]; m_cmd[2] = R2[1]; m_cmd[3] = R2[0];
      m_flt = (E != 2'b01);
      m_after_rst = 0;
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] e_op, e_cl, e_von, e_to;
    logic       e_busy;
    if (m_valid) begin
      e_op = '0; e_cl = '0; e_von = '0; e_to = '0; e_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (pv == i) begin
          if (p_open) e_op[i] = 1'b1;
          else        e_cl[i] = 1'b1;
        end
        e_von[i] = m_open[i];
        e_to[i]  = m_to[i];
        if (m_close_req(i) || m_open_req(i)) e_busy = 1'b1;
      end
      if (pv >= 0) e_busy = 1'b1;
      if (m_after_rst) e_busy = 1'b0;
      chk("m_open_pulse",  32'(open_pulse),   32'(e_op));
      chk("m_close_pulse", 32'(close_pulse),  32'(e_cl));
      chk("m_valve_on",    32'(valve_on),     32'(e_von));
      chk("m_timeout",     32'(timeout),      32'(e_to));
      chk("m_fault",       32'(fault_active), 32'(m_flt));
      chk("m_busy",        32'(busy),         32'(e_busy));
      chk("onehot_pulse",  32'($onehot0(open_pulse | close_pulse)), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish at %0t", $time);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [3:0] exp;
    bit found;
    int on_cycles;
    reset = 1'b1; R1 = 2'b00; R2 = 2'b00; E = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({open_pulse, close_pulse, valve_on, timeout}), 32'd0);
    chk("rst_flags",   32'({fault_active, busy}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Homing: close pulses 0..3, 4 cycles each, 1-cycle gap.
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp = ((k % 5) < 4) ? (4'b0001 << (k / 5)) : 4'b0000;
      chk("home_seq", 32'(close_pulse), 32'(exp));
    end
    chk("home_busy", 32'(busy), 32'd0);
    chk("home_von",  32'(valve_on), 32'd0);

    // Single open of valve0.
    @(posedge clk); #1 R1 = 2'b10;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      exp = (k >= 2 && k <= 5) ? 4'b0001 : 4'b0000;
      chk("open0_pulse", 32'(open_pulse), 32'(exp));
    end
    chk("open0_von", 32'(valve_on), 32'b0001);

    // Minimum on-time: drop command at on_cnt=2.
    repeat (2) @(posedge clk); #1 R1 = 2'b00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("minon_close", 32'(close_pulse[0]), 32'(k >= 7 && k <= 10));
      chk("minon_von",   32'(valve_on[0]),    32'(k <= 6));
    end

    // Concurrent opens, granted 0,1,2,3.
    @(posedge clk); #1 begin R1 = 2'b11; R2 = 2'b11; end
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      exp = 4'b0000;
      if (k >= 2 && ((k - 2) % 5) < 4) exp = 4'b0001 << ((k - 2) / 5);
      chk("conc_open", 32'(open_pulse), 32'(exp));
    end
    chk("conc_von", 32'(valve_on), 32'b1111);

    // Watchdog on valve3 (opened on the last cycle above, on_cnt=0).
    on_cycles = 1;
    @(posedge clk); #1 begin R1 = 2'b00; R2 = 2'b01; end
    found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (valve_on[3]) on_cycles++;
      if (timeout[3]) found = 1;
    end
    chk("wd_seen",      32'(found), 32'd1);
    chk("wd_on_cycles", 32'(on_cycles), 32'd21);
    chk("wd_timeout",   32'(timeout), 32'b1000);
    repeat (10) @(negedge clk);
    chk("wd_closed", 32'(valve_on), 32'd0);
    chk("wd_sticky", 32'(timeout), 32'b1000);
    chk("wd_noopen", 32'(open_pulse), 32'd0);
    @(posedge clk); #1 R2 = 2'b00;
    repeat (3) @(negedge clk);
    chk("wd_clear", 32'(timeout), 32'd0);
    @(posedge clk); #1 R2 = 2'b01;
    repeat (3) @(negedge clk);
    chk("wd_reopen", 32'(open_pulse), 32'b1000);
    @(posedge clk); #1 R2 = 2'b00;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (valve_on == 4'b0000 && !busy) found = 1;
    end
    chk("idle_before_fault", 32'(found), 32'd1);

    // Fault with valves 0 and 2 open.
    @(posedge clk); #1 begin R1 = 2'b10; R2 = 2'b10; end
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (valve_on == 4'b0101) found = 1;
    end
    chk("flt_setup", 32'(found), 32'd1);
    repeat (3) @(posedge clk); #1 E = 2'b00;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0) chk("flt_lat0", 32'(fault_active), 32'd0);
      if (k == 1) chk("flt_lat1", 32'(fault_active), 32'd1);
      exp = 4'b0000;
      if (k >= 2 && k <= 5)  exp = 4'b0001;
      if (k >= 7 && k <= 10) exp = 4'b0100;
      chk("flt_close", 32'(close_pulse), 32'(exp));
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("flt_no_open", 32'(open_pulse), 32'd0);
    end
    chk("flt_von", 32'(valve_on), 32'd0);
    @(posedge clk); #1 begin E = 2'b01; R2 = 2'b00; end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) chk("flt_hold",    32'(fault_active), 32'd1);
      if (k == 1) chk("flt_release", 32'(fault_active), 32'd0);
      if (k == 2) chk("flt_reopen",  32'(open_pulse),   32'b0001);
      if (k == 6) chk("flt_von0",    32'(valve_on),     32'b0001);
    end

    // Reset asserted in the middle of an open pulse.
    @(posedge clk); #1 R1 = 2'b11;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (open_pulse == 4'b0010) found = 1;
    end
    chk("rstmid_setup", 32'(found), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rstmid_before", 32'(open_pulse), 32'b0010);
    @(negedge clk);
    chk("rstmid_drop",  32'({open_pulse, close_pulse, valve_on, timeout}), 32'd0);
    chk("rstmid_flags", 32'({fault_active, busy}), 32'd0);
    R1 = 2'b00; R2 = 2'b00;
    @(posedge clk); #1 reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("rehome_busy", 32'(busy), 32'd0);
    chk("rehome_von",  32'(valve_on), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
